// File: rtl/thresholding_out_dwc.sv
// thresholding_out_dwc: re-serialises PE-lane words into R=PE/OPE narrower OPE-lane words, lane 0 first.
// Optional feature macro THRESH_DWC_TLAST_EN adds a frame counter and the m_axis_tlast output.
module thresholding_out_dwc #(
    parameter int PE          = 4,
    parameter int OPE         = 1,
    parameter int O_BITS      = 4,
    parameter int FRAME_WORDS = 16,
    localparam int IW = ((PE*O_BITS+7)/8)*8,
    localparam int OW = ((OPE*O_BITS+7)/8)*8
) (
    input  logic          ap_clk,
    input  logic          ap_rst,
    output logic          s_axis_tready,
    input  logic          s_axis_tvalid,
    input  logic [IW-1:0] s_axis_tdata,
    input  logic          m_axis_tready,
    output logic          m_axis_tvalid,
    output logic [OW-1:0] m_axis_tdata
`ifdef THRESH_DWC_TLAST_EN
    ,
    output logic          m_axis_tlast
`endif
);
    localparam int R    = PE / OPE;
    localparam int IDXW = (R > 1) ? $clog2(R) : 1;
    localparam int SW   = OPE * O_BITS;
    localparam int BW   = PE * O_BITS;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(R - 1);

    generate
        if (PE % OPE != 0) begin : g_bad_ratio
            $error("thresholding_out_dwc: PE must be a multiple of OPE");
        end
    endgenerate

    logic [BW-1:0]   r_buf;
    logic            r_buf_vld;
    logic [IDXW-1:0] r_idx;
    logic [OW-1:0]   r_out_data;
    logic            r_out_vld;

    logic            w_ld;
    logic            w_last;
    logic            w_in_xfer;
    logic            w_out_hs;
    logic [SW-1:0]   w_slice;
    logic [OW-1:0]   w_out_nxt;

    assign w_ld      = r_buf_vld && (!r_out_vld || m_axis_tready);
    assign w_last    = (r_idx == LAST_IDX);
    assign w_out_hs  = r_out_vld && m_axis_tready;
    // Ready only when the buffer is empty or its final slice leaves this cycle.
    assign s_axis_tready = !ap_rst && (!r_buf_vld || (w_ld && w_last));
    assign w_in_xfer = s_axis_tvalid && s_axis_tready;
    assign w_slice   = r_buf[32'(r_idx)*SW +: SW];

    always_comb begin
        w_out_nxt = '0;
        w_out_nxt[SW-1:0] = w_slice;
    end

    always_ff @(posedge ap_clk) begin
        if (w_in_xfer) begin
            r_buf <= s_axis_tdata[BW-1:0];
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_buf_vld  <= 1'b0;
            r_idx      <= '0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
        end else begin
            if (w_in_xfer) begin
                r_buf_vld <= 1'b1;
            end else if (w_ld && w_last) begin
                r_buf_vld <= 1'b0;
            end
            if (w_ld) begin
                r_out_data <= w_out_nxt;
                r_out_vld  <= 1'b1;
                r_idx      <= w_last ? '0 : r_idx + 1'b1;
            end else if (w_out_hs) begin
                r_out_vld  <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = r_out_vld;
    assign m_axis_tdata  = r_out_data;

`ifdef THRESH_DWC_TLAST_EN
    localparam int FCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(FRAME_WORDS - 1);

    generate
        if (FRAME_WORDS < 1) begin : g_bad_frame
            $error("thresholding_out_dwc: FRAME_WORDS must be >= 1");
        end
    endgenerate

    logic [FCW-1:0] r_frame_cnt;
    logic           r_tlast;
    logic [FCW-1:0] w_frame_cnt_nxt;
    logic [FCW-1:0] w_load_pos;

    // A slice loaded while the current one is handed off sits one position further on.
    always_comb begin
        w_frame_cnt_nxt = (r_frame_cnt == FC_LAST) ? '0 : r_frame_cnt + 1'b1;
        w_load_pos      = w_out_hs ? w_frame_cnt_nxt : r_frame_cnt;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_frame_cnt <= '0;
            r_tlast     <= 1'b0;
        end else begin
            if (w_out_hs) begin
                r_frame_cnt <= w_frame_cnt_nxt;
            end
            if (w_ld) begin
                r_tlast <= (w_load_pos == FC_LAST);
            end
        end
    end

    assign m_axis_tlast = r_tlast;
`endif

endmodule

// File: tb/tb_thresholding_out_dwc.sv
// Bench for thresholding_out_dwc: three instances (R=4, R=2, R=1) driven with directed and random traffic.
module tb_thresholding_out_dwc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // A: PE=4 OPE=1 ; B: PE=4 OPE=2 ; C: PE=2 OPE=2
    logic a_rst = 1'b1, a_ivld = 1'b0, a_ordy = 1'b1, a_irdy, a_ovld;
    logic [15:0] a_idata = '0;
    logic [7:0]  a_odata;
    logic b_rst = 1'b1, b_ivld = 1'b0, b_ordy = 1'b1, b_irdy, b_ovld;
    logic [15:0] b_idata = '0;
    logic [7:0]  b_odata;
    logic c_rst = 1'b1, c_ivld = 1'b0, c_ordy = 1'b1, c_irdy, c_ovld;
    logic [7:0]  c_idata = '0;
    logic [7:0]  c_odata;
`ifdef THRESH_DWC_TLAST_EN
    logic a_olast, b_olast, c_olast;
`endif

    thresholding_out_dwc #(.PE(4), .OPE(1), .O_BITS(4), .FRAME_WORDS(16)) dut_a (
        .ap_clk(clk), .ap_rst(a_rst), .s_axis_tready(a_irdy), .s_axis_tvalid(a_ivld),
        .s_axis_tdata(a_idata), .m_axis_tready(a_ordy), .m_axis_tvalid(a_ovld),
        .m_axis_tdata(a_odata)
`ifdef THRESH_DWC_TLAST_EN
        , .m_axis_tlast(a_olast)
`endif
    );

    thresholding_out_dwc #(.PE(4), .OPE(2), .O_BITS(4), .FRAME_WORDS(6)) dut_b (
        .ap_clk(clk), .ap_rst(b_rst), .s_axis_tready(b_irdy), .s_axis_tvalid(b_ivld),
        .s_axis_tdata(b_idata), .m_axis_tready(b_ordy), .m_axis_tvalid(b_ovld),
        .m_axis_tdata(b_odata)
`ifdef THRESH_DWC_TLAST_EN
        , .m_axis_tlast(b_olast)
`endif
    );

    thresholding_out_dwc #(.PE(2), .OPE(2), .O_BITS(4), .FRAME_WORDS(16)) dut_c (
        .ap_clk(clk), .ap_rst(c_rst), .s_axis_tready(c_irdy), .s_axis_tvalid(c_ivld),
        .s_axis_tdata(c_idata), .m_axis_tready(c_ordy), .m_axis_tvalid(c_ovld),
        .m_axis_tdata(c_odata)
`ifdef THRESH_DWC_TLAST_EN
        , .m_axis_tlast(c_olast)
`endif
    );

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
            @(negedge clk);
            checks++;
            if ({a_irdy, b_irdy, c_irdy} !== 3'b000) begin
                errors++;
                $display("FAIL reset_tready got %b want 000", {a_irdy, b_irdy, c_irdy});
            end
        end
        @(posedge clk); #1;
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_ovld, b_ovld, c_ovld} !== 3'b000) begin
            errors++;
            $display("FAIL reset_tvalid got %b want 000", {a_ovld, b_ovld, c_ovld});
        end
        checks++;
        if ({a_odata, b_odata, c_odata} !== 24'h0) begin
            errors++;
            $display("FAIL reset_tdata got %h want 000000", {a_odata, b_odata, c_odata});
        end
        checks++;
        if ({a_irdy, b_irdy, c_irdy} !== 3'b111) begin
            errors++;
            $display("FAIL post_reset_tready got %b want 111", {a_irdy, b_irdy, c_irdy});
        end
    endtask

    task automatic test_plain();
        bit       exp_v [7] = '{0, 0, 1, 1, 1, 1, 0};
        bit       exp_r [7] = '{1, 0, 0, 0, 1, 1, 1};
        bit [7:0] exp_d [7] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            a_ivld = (c == 0); a_idata = 16'h4321; a_ordy = 1'b1;
            @(negedge clk);
            checks++;
            if (a_irdy !== exp_r[c]) begin
                errors++; $display("FAIL plain_tready c=%0d got %b want %b", c, a_irdy, exp_r[c]);
            end
            checks++;
            if (a_ovld !== exp_v[c]) begin
                errors++; $display("FAIL plain_tvalid c=%0d got %b want %b", c, a_ovld, exp_v[c]);
            end
            if (exp_v[c]) begin
                checks++;
                if (a_odata !== exp_d[c]) begin
                    errors++; $display("FAIL plain_tdata c=%0d got %h want %h", c, a_odata, exp_d[c]);
                end
            end
        end
        a_ivld = 1'b0;
    endtask

    task automatic test_backpressure();
        bit       exp_v [12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        bit       exp_r [12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        bit [7:0] exp_d [12] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02,
                                 8'h02, 8'h02, 8'h03, 8'h04, 8'h00};
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            a_ivld = (c == 0); a_idata = 16'h4321; a_ordy = !(c >= 3 && c <= 7);
            @(negedge clk);
            checks++;
            if (a_irdy !== exp_r[c]) begin
                errors++; $display("FAIL bp_tready c=%0d got %b want %b", c, a_irdy, exp_r[c]);
            end
            checks++;
            if (a_ovld !== exp_v[c]) begin
                errors++; $display("FAIL bp_tvalid c=%0d got %b want %b", c, a_ovld, exp_v[c]);
            end
            if (exp_v[c]) begin
                checks++;
                if (a_odata !== exp_d[c]) begin
                    errors++; $display("FAIL bp_tdata c=%0d got %h want %h", c, a_odata, exp_d[c]);
                end
            end
        end
        a_ivld = 1'b0; a_ordy = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit        rst_s [10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        bit        vld_s [10] = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        bit [15:0] dat_s [10] = '{16'h4321, 0, 0, 16'hAAAA, 0, 0, 0, 0, 0, 0};
        bit        exp_v [10] = '{0, 0, 1, 0, 0, 1, 1, 1, 1, 0};
        bit        exp_r [10] = '{1, 0, 0, 1, 0, 0, 0, 1, 1, 1};
        bit [7:0]  exp_d [10] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00,
                                  8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h00};
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            a_rst = rst_s[c]; a_ivld = vld_s[c]; a_idata = dat_s[c]; a_ordy = 1'b1;
            @(negedge clk);
            checks++;
            if (a_irdy !== exp_r[c]) begin
                errors++; $display("FAIL rstmid_tready c=%0d got %b want %b", c, a_irdy, exp_r[c]);
            end
            checks++;
            if (a_ovld !== exp_v[c]) begin
                errors++; $display("FAIL rstmid_tvalid c=%0d got %b want %b", c, a_ovld, exp_v[c]);
            end
            if (exp_v[c]) begin
                checks++;
                if (a_odata !== exp_d[c]) begin
                    errors++; $display("FAIL rstmid_tdata c=%0d got %h want %h", c, a_odata, exp_d[c]);
                end
            end
        end
        a_ivld = 1'b0; a_rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit        vld_s [7] = '{1, 1, 1, 0, 0, 0, 0};
        bit [15:0] dat_s [7] = '{16'h4321, 16'h8765, 16'h8765, 0, 0, 0, 0};
        bit        exp_v [7] = '{0, 0, 1, 1, 1, 1, 0};
        bit        exp_r [7] = '{1, 0, 1, 0, 1, 1, 1};
        bit [7:0]  exp_d [7] = '{8'h00, 8'h00, 8'h21, 8'h43, 8'h65, 8'h87, 8'h00};
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            b_ivld = vld_s[c]; b_idata = dat_s[c]; b_ordy = 1'b1;
            @(negedge clk);
            checks++;
            if (b_irdy !== exp_r[c]) begin
                errors++; $display("FAIL b2b_tready c=%0d got %b want %b", c, b_irdy, exp_r[c]);
            end
            checks++;
            if (b_ovld !== exp_v[c]) begin
                errors++; $display("FAIL b2b_tvalid c=%0d got %b want %b", c, b_ovld, exp_v[c]);
            end
            if (exp_v[c]) begin
                checks++;
                if (b_odata !== exp_d[c]) begin
                    errors++; $display("FAIL b2b_tdata c=%0d got %h want %h", c, b_odata, exp_d[c]);
                end
            end
        end
        b_ivld = 1'b0;
    endtask

    // R==1: each accepted word should reappear unchanged, in order.
    task automatic test_random_r1();
        logic [7:0] q[$];
        logic [7:0] exp, prev_d;
        int  sent = 0, rcvd = 0, cyc = 0;
        bit  prev_hs = 0, prev_stall = 0;
        while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            if (!c_ivld || prev_hs) begin
                c_ivld  = (sent < 1000) && ($urandom_range(3) != 0);
                c_idata = 8'($urandom);
            end
            c_ordy = ($urandom_range(2) != 0);
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (c_ovld !== 1'b1 || c_odata !== prev_d) begin
                    errors++;
                    $display("FAIL r1_stable cyc=%0d got %b/%h want 1/%h", cyc, c_ovld, c_odata, prev_d);
                end
            end
            if (c_ovld && c_ordy) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL r1_extra cyc=%0d got %h want none", cyc, c_odata);
                end else begin
                    exp = q.pop_front();
                    if (c_odata !== exp) begin
                        errors++; $display("FAIL r1_data cyc=%0d got %h want %h", cyc, c_odata, exp);
                    end
                end
                rcvd++;
            end
            prev_stall = c_ovld && !c_ordy;
            prev_d     = c_odata;
            prev_hs    = c_ivld && c_irdy;
            if (prev_hs) begin
                q.push_back(c_idata);
                sent++;
            end
        end
        c_ivld = 1'b0; c_ordy = 1'b1;
        checks++;
        if (sent != 1000 || rcvd != 1000) begin
            errors++; $display("FAIL r1_count got sent=%0d rcvd=%0d want 1000/1000", sent, rcvd);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (c_ovld !== 1'b0) begin
            errors++; $display("FAIL r1_drain got tvalid=%b want 0", c_ovld);
        end
    endtask

    // R==2: each accepted word yields its low byte then its high byte.
    task automatic test_random_r2();
        logic [7:0] q[$];
        logic [7:0] exp, prev_d;
        int  sent = 0, rcvd = 0, cyc = 0;
        bit  prev_hs = 0, prev_stall = 0;
        while ((sent < 300 || q.size() != 0) && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            if (!b_ivld || prev_hs) begin
                b_ivld  = (sent < 300) && ($urandom_range(3) != 0);
                b_idata = 16'($urandom);
            end
            b_ordy = ($urandom_range(3) != 0);
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (b_ovld !== 1'b1 || b_odata !== prev_d) begin
                    errors++;
                    $display("FAIL r2_stable cyc=%0d got %b/%h want 1/%h", cyc, b_ovld, b_odata, prev_d);
                end
            end
            if (b_ovld && b_ordy) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL r2_extra cyc=%0d got %h want none", cyc, b_odata);
                end else begin
                    exp = q.pop_front();
                    if (b_odata !== exp) begin
                        errors++; $display("FAIL r2_data cyc=%0d got %h want %h", cyc, b_odata, exp);
                    end
                end
                rcvd++;
            end
            prev_stall = b_ovld && !b_ordy;
            prev_d     = b_odata;
            prev_hs    = b_ivld && b_irdy;
            if (prev_hs) begin
                for (int j = 0; j < 2; j++) q.push_back(8'((b_idata >> (8 * j)) % 256));
                sent++;
            end
        end
        b_ivld = 1'b0; b_ordy = 1'b1;
        checks++;
        if (sent != 300 || rcvd != 600) begin
            errors++; $display("FAIL r2_count got sent=%0d rcvd=%0d want 300/600", sent, rcvd);
        end
    endtask

`ifdef THRESH_DWC_TLAST_EN
    // Frame of 6 narrow words: tlast on every 6th output handshake after reset.
    task automatic test_tlast();
        int  n = 0, sent = 0, cyc = 0;
        bit  prev_hs = 0;
        @(posedge clk); #1;
        b_rst = 1'b1; b_ivld = 1'b0;
        @(posedge clk); #1;
        b_rst = 1'b0;
        while (n < 12 && cyc < 500) begin
            if (cyc != 0) begin
                @(posedge clk); #1;
            end
            cyc++;
            if (!b_ivld || prev_hs) begin
                b_ivld  = (sent < 6) && ($urandom_range(2) != 0);
                b_idata = 16'($urandom);
            end
            b_ordy = ($urandom_range(2) != 0);
            @(negedge clk);
            if (b_ovld && b_ordy) begin
                n++;
                checks++;
                if (b_olast !== (n % 6 == 0)) begin
                    errors++; $display("FAIL tlast n=%0d got %b want %b", n, b_olast, (n % 6 == 0));
                end
            end
            prev_hs = b_ivld && b_irdy;
            if (prev_hs) sent++;
        end
        b_ivld = 1'b0; b_ordy = 1'b1;
        checks++;
        if (n != 12) begin
            errors++; $display("FAIL tlast_count got %0d want 12", n);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_plain();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random_r1();
        test_random_r2();
`ifdef THRESH_DWC_TLAST_EN
        test_tlast();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
